// File: rtl/zx_memory_mapper.sv
// Memory paging unit for the ZX Spectrum 128/+2A/+3 core with DivMMC.
// Decodes the 7FFD/1FFD/E3 ports, runs the DivMMC automapper and drives the SRAM/ROM selects.
// Optional +3 paging (1FFD port, special all-RAM modes) is enabled by defining PLUS3_EN.
module zx_memory_mapper #(
  parameter int unsigned RAM_AW   = 21,
  parameter int unsigned BANK_W   = 3,
  parameter int unsigned DIV_PW   = 4,
  parameter int unsigned DIV_BASE = 'h40000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  input  logic              mreq,
  input  logic              iorq,
  input  logic              wr,
  input  logic              m1,
  input  logic              rfsh,
  input  logic [15:0]       a,
  input  logic [7:0]        d,
  output logic [RAM_AW-1:0] sramA,
  output logic              sramWe,
  output logic [1:0]        romSel,
  output logic [15:0]       romA,
  output logic              vduPage,
  output logic              cn
);

  localparam logic [RAM_AW-1:0] DivBase = RAM_AW'(DIV_BASE);

  logic [BANK_W-1:0] bank_q, bank_d;
  logic              vdu_q, vdu_d;
  logic              rom0_q, rom0_d;
  logic              lock_q, lock_d;
  logic              conmem_q, conmem_d;
  logic [DIV_PW-1:0] div_page_q, div_page_d;
  logic              mapram_q, mapram_d;
  logic              m1on_q, m1on_d;
  logic              automap_q, automap_d;

  logic              port_7ffd, port_e3, fetch, map, special, rom1;
  logic [1:0]        trap_page;
  logic [BANK_W-1:0] bank_wr;

`ifdef PLUS3_EN
  logic       special_q, special_d;
  logic [1:0] config_q, config_d;
  logic       port_1ffd;

  // Bank for quadrant q in each special all-RAM configuration
  function automatic logic [2:0] special_bank(input logic [1:0] cfg, input logic [1:0] q);
    unique case (cfg)
      2'd0:    special_bank = {1'b0, q};
      2'd1:    special_bank = {1'b1, q};
      2'd2:    special_bank = (q == 2'd3) ? 3'd3 : {1'b1, q};
      default: special_bank = (q == 2'd0) ? 3'd4 : (q == 2'd1) ? 3'd7 : (q == 2'd2) ? 3'd6 : 3'd3;
    endcase
  endfunction

  assign port_7ffd = !iorq && !wr && !a[15] && !a[14] && !a[1];
  assign port_1ffd = !iorq && !wr && (a[15:12] == 4'b0001) && !a[1];
  assign special   = special_q;
  assign rom1      = config_q[1];
  assign trap_page = {rom1, rom0_q};
`else
  assign port_7ffd = !iorq && !wr && !a[15] && !a[1];
  assign special   = 1'b0;
  assign rom1      = 1'b0;
  // 48K BASIC traps qualify whenever rom0 selects the 48K ROM
  assign trap_page = {1'b1, rom0_q};
`endif

  assign port_e3 = !iorq && !wr && (a[7:0] == 8'hE3);
  // Refresh cycles never count as fetches
  assign fetch   = !mreq && !m1 && rfsh;
  assign map     = conmem_q | automap_q;

  // Bank value from a 7FFD write: d[2:0] low, extra bits taken from d[7] downwards
  always_comb begin
    bank_wr = '0;
    for (int i = 0; i < BANK_W; i++) begin
      if (i < 3) bank_wr[i] = d[i];
      else       bank_wr[i] = d[7 - (BANK_W - 1 - i)];
    end
  end

  // Next state: port writes, automapper and synchronous reset
  always_comb begin
    bank_d     = bank_q;
    vdu_d      = vdu_q;
    rom0_d     = rom0_q;
    lock_d     = lock_q;
    conmem_d   = conmem_q;
    div_page_d = div_page_q;
    mapram_d   = mapram_q;
    m1on_d     = m1on_q;
    automap_d  = automap_q;
`ifdef PLUS3_EN
    special_d  = special_q;
    config_d   = config_q;
    if (port_1ffd && !lock_q) begin
      special_d = d[0];
      config_d  = d[2:1];
    end
`endif
    if (port_7ffd && !lock_q) begin
      bank_d = bank_wr;
      vdu_d  = d[3];
      rom0_d = d[4];
      lock_d = d[5];
    end
    if (port_e3) begin
      conmem_d   = d[7];
      div_page_d = d[DIV_PW-1:0];
      mapram_d   = mapram_q | d[6];
    end
    if (fetch) begin
      if (a == 16'h0000 || a == 16'h0008 || a == 16'h0038 || a == 16'h0066) begin
        m1on_d = 1'b1;
      end else if ((a == 16'h04C6 || a == 16'h0562) && trap_page == 2'b11) begin
        m1on_d = 1'b1;
      end else if (a[15:3] == 13'h3FF) begin
        m1on_d = 1'b0;
      end else if (a[15:8] == 8'h3D && trap_page == 2'b11) begin
        m1on_d    = 1'b1;
        automap_d = 1'b1;
      end
    end
    if (m1) automap_d = m1on_q;
    if (!reset) begin
      bank_d     = '0;
      vdu_d      = 1'b0;
      rom0_d     = 1'b0;
      lock_d     = 1'b0;
      conmem_d   = 1'b0;
      div_page_d = '0;
      mapram_d   = 1'b0;
      m1on_d     = 1'b0;
      automap_d  = 1'b0;
`ifdef PLUS3_EN
      special_d  = 1'b0;
      config_d   = 2'b00;
`endif
    end
  end

  // State register; reset is synchronous and gated by ce like every other update
  always_ff @(posedge clock) begin
    if (ce) begin
      bank_q     <= bank_d;
      vdu_q      <= vdu_d;
      rom0_q     <= rom0_d;
      lock_q     <= lock_d;
      conmem_q   <= conmem_d;
      div_page_q <= div_page_d;
      mapram_q   <= mapram_d;
      m1on_q     <= m1on_d;
      automap_q  <= automap_d;
`ifdef PLUS3_EN
      special_q  <= special_d;
      config_q   <= config_d;
`endif
    end
  end

  logic [BANK_W-1:0] sel_bank;
  logic [DIV_PW-1:0] div_sel;
  logic              is_bank, is_div, writable, contended;

  // Address decode: pick the target (bank, DivMMC RAM or ROM) for the current bus address
  always_comb begin
    sel_bank = '0;
    div_sel  = '0;
    is_bank  = 1'b0;
    is_div   = 1'b0;
    writable = 1'b0;
    romSel   = 2'd0;
    sramA    = '0;
    if (special) begin
`ifdef PLUS3_EN
      sel_bank = BANK_W'(special_bank(config_q, a[15:14]));
`endif
      is_bank  = 1'b1;
      writable = 1'b1;
    end else begin
      unique case (a[15:14])
        2'd0: begin
          if (map) begin
            if (!a[13]) begin
              if (mapram_q) begin
                is_div  = 1'b1;
                div_sel = DIV_PW'(3);
              end else begin
                romSel = 2'd2;
              end
            end else begin
              is_div   = 1'b1;
              div_sel  = div_page_q;
              writable = 1'b1;
            end
          end else begin
            romSel = 2'd1;
          end
        end
        2'd1: begin
          is_bank  = 1'b1;
          sel_bank = BANK_W'(5);
          writable = 1'b1;
        end
        2'd2: begin
          is_bank  = 1'b1;
          sel_bank = BANK_W'(2);
          writable = 1'b1;
        end
        default: begin
          is_bank  = 1'b1;
          sel_bank = bank_q;
          writable = 1'b1;
        end
      endcase
    end
    if (is_bank) sramA = RAM_AW'({sel_bank, a[13:0]});
    if (is_div)  sramA = DivBase + RAM_AW'({div_sel, a[12:0]});
  end

  // Contention: +3 contends banks 4-7, 128K contends the odd banks
  always_comb begin
`ifdef PLUS3_EN
    contended = ((sel_bank >> 2) == BANK_W'(1));
`else
    contended = sel_bank[0];
`endif
  end

  assign cn      = is_bank && contended;
  assign sramWe  = !(!mreq && !wr && (is_bank || is_div) && writable);
  assign romA    = {rom1, rom0_q, a[13:0]};
  assign vduPage = vdu_q;

endmodule

// File: tb/tb_zx_memory_mapper.sv
// Directed self-checking bench for zx_memory_mapper (default build, PLUS3_EN undefined).
module tb_zx_memory_mapper;

  logic        clock = 1'b0;
  logic        reset, ce, mreq, iorq, wr, m1, rfsh;
  logic [15:0] a;
  logic [7:0]  d;
  logic [20:0] sramA;
  logic        sramWe;
  logic [1:0]  romSel;
  logic [15:0] romA;
  logic        vduPage, cn;

  int tests_run = 0;
  int tests_failed = 0;

  zx_memory_mapper dut (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .mreq    (mreq),
    .iorq    (iorq),
    .wr      (wr),
    .m1      (m1),
    .rfsh    (rfsh),
    .a       (a),
    .d       (d),
    .sramA   (sramA),
    .sramWe  (sramWe),
    .romSel  (romSel),
    .romA    (romA),
    .vduPage (vduPage),
    .cn      (cn)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    mreq = 1'b1; iorq = 1'b1; wr = 1'b1; m1 = 1'b1; rfsh = 1'b1;
    a = 16'h0000; d = 8'h00;
  endtask

  task automatic io_write(input logic [15:0] port, input logic [7:0] val);
    idle();
    a = port; d = val; iorq = 1'b0; wr = 1'b0;
    tick();
    tick();
    idle();
    tick();
  endtask

  task automatic mem_rd(input logic [15:0] addr);
    idle();
    a = addr; mreq = 1'b0;
    #1;
  endtask

  task automatic mem_wr(input logic [15:0] addr);
    idle();
    a = addr; mreq = 1'b0; wr = 1'b0;
    #1;
  endtask

  task automatic fetch_begin(input logic [15:0] addr);
    idle();
    a = addr; mreq = 1'b0; m1 = 1'b0;
    #1;
  endtask

  // Bus returns to idle with m1 high so the deferred automap decision is taken
  task automatic fetch_done();
    idle();
    tick();
  endtask

  initial begin
    idle();
    ce = 1'b1;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    // Reset state
    mem_rd(16'h0000);
    check("rst_romSel", 32'(romSel), 32'd1);
    check("rst_romA", 32'(romA), 32'h0000);
    check("rst_vdu", 32'(vduPage), 32'd0);
    check("rst_we", 32'(sramWe), 32'd1);
    check("rst_cn", 32'(cn), 32'd0);

    // Basic 128K paging
    io_write(16'h7FFD, 8'h07);
    mem_rd(16'hC123);
    check("b7_romSel", 32'(romSel), 32'd0);
    check("b7_sramA", 32'(sramA), 32'h1C123);
    check("b7_cn", 32'(cn), 32'd1);
    mem_wr(16'hC123);
    check("b7_we", 32'(sramWe), 32'd0);
    mem_rd(16'h4000);
    check("q1_sramA", 32'(sramA), 32'h14000);
    check("q1_cn", 32'(cn), 32'd1);
    mem_rd(16'h8000);
    check("q2_sramA", 32'(sramA), 32'h08000);
    check("q2_cn", 32'(cn), 32'd0);
    io_write(16'h7FFD, 8'h08);
    check("vdu_set", 32'(vduPage), 32'd1);
    mem_rd(16'hC000);
    check("b0_sramA", 32'(sramA), 32'h00000);
    check("b0_cn", 32'(cn), 32'd0);

    // Lock
    io_write(16'h7FFD, 8'h20);
    io_write(16'h7FFD, 8'h01);
    mem_rd(16'hC000);
    check("lock_bank", 32'(sramA), 32'h00000);
    check("lock_vdu", 32'(vduPage), 32'd0);
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    io_write(16'h7FFD, 8'h01);
    mem_rd(16'hC000);
    check("unlock_sramA", 32'(sramA), 32'h04000);
    check("unlock_cn", 32'(cn), 32'd1);

    // Reset with ce low has no effect
    io_write(16'h7FFD, 8'h03);
    idle();
    ce = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    ce = 1'b1;
    tick();
    mem_rd(16'hC000);
    check("ce0_rst", 32'(sramA), 32'h0C000);

    // Deferred entry at 0038
    fetch_begin(16'h0038);
    check("trap_pre", 32'(romSel), 32'd1);
    tick();
    check("trap_same_m1", 32'(romSel), 32'd1);
    fetch_done();
    fetch_begin(16'h0039);
    check("trap_next", 32'(romSel), 32'd2);
    tick();
    fetch_done();

    // DivMMC RAM and mapram
    io_write(16'h00E3, 8'h45);
    mem_wr(16'h2000);
    check("div_we", 32'(sramWe), 32'd0);
    check("div_sramA", 32'(sramA), 32'h4A000);
    mem_wr(16'h0000);
    check("mapram_we", 32'(sramWe), 32'd1);
    check("mapram_sramA", 32'(sramA), 32'h46000);
    check("mapram_romSel", 32'(romSel), 32'd0);
    io_write(16'h00E3, 8'h00);
    mem_rd(16'h0000);
    check("mapram_sticky", 32'(romSel), 32'd0);
    mem_rd(16'h2000);
    check("div_page0", 32'(sramA), 32'h40000);

    // Deferred exit at 1FF8
    fetch_begin(16'h1FF8);
    tick();
    check("exit_same_m1", 32'(romSel), 32'd0);
    fetch_done();
    mem_rd(16'h1FF8);
    check("exit_after", 32'(romSel), 32'd1);

    // 3Dxx with rom0 = 0: no trap
    fetch_begin(16'h3D00);
    tick();
    check("3d_rom0_0", 32'(romSel), 32'd1);
    fetch_done();
    mem_rd(16'h0100);
    check("3d_rom0_0_after", 32'(romSel), 32'd1);

    // 3Dxx with rom0 = 1: immediate entry inside the same M1
    io_write(16'h7FFD, 8'h10);
    fetch_begin(16'h3D00);
    check("3d_pre", 32'(romSel), 32'd1);
    tick();
    check("3d_imm_romSel", 32'(romSel), 32'd0);
    check("3d_imm_sramA", 32'(sramA), 32'h41D00);
    check("3d_romA", 32'(romA), 32'h7D00);
    fetch_done();
    mem_rd(16'h0100);
    check("3d_held", 32'(sramA), 32'h46100);
    fetch_begin(16'h1FFF);
    tick();
    fetch_done();
    mem_rd(16'h0100);
    check("3d_release", 32'(romSel), 32'd1);
    check("rom1_romA", 32'(romA), 32'h4100);

    // 48K BASIC trap at 04C6
    fetch_begin(16'h04C6);
    check("04c6_pre", 32'(romSel), 32'd1);
    tick();
    fetch_done();
    mem_rd(16'h0100);
    check("04c6_after", 32'(romSel), 32'd0);

    idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
